alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the team's 8-bit combinational calculator ALU.
- Keeps the same 4-bit opcode map and flag-bit meanings, at generic WIDTH.
- Adds a valid/ready handshake on input and output, an iterative shift-add multiplier, and an iterative restoring divider.
- Full-precision results: high product half and remainder on a second output.
- Sits between the calculator operand/opcode registers and the display/result register stage.

---
 rtl/alu_seq.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : multi-cycle calculator ALU with valid/ready handshakes.
//
// Successor to the 8-bit combinational calculator ALU. It keeps the same
// 4-bit opcode map and flag meanings, but works at a generic WIDTH. MUL is an
// iterative shift-add multiplier and DIV is an iterative restoring divider.
// Both return full-precision results: the high product half or the remainder
// appears on dout_hi.
//
// Parameters:
//   WIDTH     operand/result width in bits (>= 4)
//   CNT_W     width of the iteration counter
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  inA/inB/sel_tmp are valid
//   in_ready  block is idle and can accept an operation
//   inA, inB  unsigned operands (inB is also the shift amount)
//   sel_tmp   opcode: 0 ADD 1 SUB 2 MUL 3 DIV 4 SHL 5 SHR 6 AND 7 OR 8 XOR
//             9 XNOR A NAND B NOR, C-F invalid
//   out_valid result is valid
//   out_ready consumer accepts the result
//   dout      result (low half)
//   dout_hi   MUL high half, DIV remainder, 0 otherwise
//   flags     [0] zero [1] shift-out [2] carry/overflow/div0 [3] borrow/A<B
//
// Optional feature (macro ALU_SEQ_MUL_EARLY_TERM_EN):
//   When defined, MUL stops iterating as soon as the remaining multiplier
//   bits are all zero. Product and flags are the same as a full-length run.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic [3:0]         sel_tmp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]   dout_hi,
  output logic [3:0]         flags
);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpMul  = 4'h2;
  localparam logic [3:0] OpDiv  = 4'h3;
  localparam logic [3:0] OpShl  = 4'h4;
  localparam logic [3:0] OpShr  = 4'h5;
  localparam logic [3:0] OpAnd  = 4'h6;
  localparam logic [3:0] OpOr   = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpXnor = 4'h9;
  localparam logic [3:0] OpNand = 4'hA;
  localparam logic [3:0] OpNor  = 4'hB;

  localparam logic [WIDTH-1:0] ShiftLimit = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] LastIter   = CNT_W'(WIDTH - 1);

`ifdef ALU_SEQ_MUL_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_op;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]      r_mplier;
  logic [2*WIDTH-1:0]    r_prod;
  logic [WIDTH-1:0]      r_divisor;
  logic [WIDTH-1:0]      r_dividend;
  logic [WIDTH-1:0]      r_rem;
  logic [WIDTH-1:0]      r_quot;
  logic [WIDTH-1:0]      r_dout;
  logic [WIDTH-1:0]      r_doutHi;
  logic [3:0]            r_flags;

  logic [2*WIDTH-1:0]    w_mcand;
  logic [WIDTH-1:0]      w_mplier;
  logic [2*WIDTH-1:0]    w_prod;
  logic [WIDTH-1:0]      w_divisor;
  logic [WIDTH-1:0]      w_dividend;
  logic [WIDTH-1:0]      w_rem;
  logic [WIDTH-1:0]      w_quot;

  logic [2*WIDTH-1:0]    w_mcandNext;
  logic [WIDTH-1:0]      w_mplierNext;
  logic [2*WIDTH-1:0]    w_prodNext;
  logic [WIDTH-1:0]      w_dividendNext;
  logic [WIDTH:0]        w_remShift;
  logic                  w_remGeq;
  logic [WIDTH-1:0]      w_remNext;
  logic [WIDTH-1:0]      w_quotNext;
  logic [3:0]            w_mulFlags;
  logic [3:0]            w_divFlags;

  logic [WIDTH:0]        w_addWide;
  logic [WIDTH:0]        w_shlWide;
  logic [WIDTH:0]        w_shrWide;
  logic [WIDTH-1:0]      w_scDout;
  logic [WIDTH-1:0]      w_scHi;
  logic [3:0]            w_scFlags;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign dout      = r_dout;
  assign dout_hi   = r_doutHi;
  assign flags     = r_flags;

  // While idle the iteration datapath works directly on the live inputs, so
  // the accept edge already performs the first MUL/DIV iteration. Once busy
  // it works on the registered partial results.
  always_comb begin
    w_mcand    = r_mcand;
    w_mplier   = r_mplier;
    w_prod     = r_prod;
    w_divisor  = r_divisor;
    w_dividend = r_dividend;
    w_rem      = r_rem;
    w_quot     = r_quot;
    if (r_state == IDLE) begin
      w_mcand    = {{WIDTH{1'b0}}, inA};
      w_mplier   = inB;
      w_prod     = '0;
      w_divisor  = inB;
      w_dividend = inA;
      w_rem      = '0;
      w_quot     = '0;
    end
  end

  // One shift-add multiplier step: add the shifted multiplicand when the
  // current multiplier LSB is set, then move on to the next multiplier bit.
  assign w_prodNext   = w_prod + (w_mplier[0] ? w_mcand : '0);
  assign w_mcandNext  = w_mcand << 1;
  assign w_mplierNext = w_mplier >> 1;
  assign w_mulFlags   = {1'b0, (w_prodNext[2*WIDTH-1:WIDTH] != '0), 1'b0,
                         (w_prodNext[WIDTH-1:0] == '0)};

  // One restoring divider step. When the trial subtraction succeeds the
  // difference is below the divisor, so the low WIDTH bits of the shifted
  // remainder minus the divisor are exact.
  assign w_remShift     = {w_rem, w_dividend[WIDTH-1]};
  assign w_remGeq       = (w_remShift >= {1'b0, w_divisor});
  assign w_remNext      = w_remGeq ? (w_remShift[WIDTH-1:0] - w_divisor)
                                   : w_remShift[WIDTH-1:0];
  assign w_quotNext     = (w_quot << 1) | {{(WIDTH-1){1'b0}}, w_remGeq};
  assign w_dividendNext = w_dividend << 1;
  // With a non-zero divisor the quotient is zero exactly when A < B, so one
  // compare drives both the zero and the A<B flag.
  assign w_divFlags     = {(w_quotNext == '0), 2'b00, (w_quotNext == '0)};

  // The extra top bit of the left shift and the extra bottom bit of the right
  // shift catch the last bit shifted out for amounts 1..WIDTH.
  assign w_addWide = {1'b0, inA} + {1'b0, inB};
  assign w_shlWide = {1'b0, inA} << inB;
  assign w_shrWide = {inA, 1'b0} >> inB;

  // Results of all single-cycle opcodes, registered at the accept edge.
  always_comb begin
    w_scDout  = '0;
    w_scHi    = '0;
    w_scFlags = '0;
    case (sel_tmp)
      OpAdd: begin
        w_scDout     = w_addWide[WIDTH-1:0];
        w_scFlags[2] = w_addWide[WIDTH];
      end
      OpSub: begin
        w_scDout     = inA - inB;
        w_scFlags[3] = (inA < inB);
      end
      OpDiv: begin
        w_scFlags[2] = 1'b1;
      end
      OpShl: begin
        if (inB < ShiftLimit) begin
          w_scDout     = w_shlWide[WIDTH-1:0];
          w_scFlags[1] = w_shlWide[WIDTH];
        end
      end
      OpShr: begin
        if (inB < ShiftLimit) begin
          w_scDout     = w_shrWide[WIDTH:1];
          w_scFlags[1] = w_shrWide[0];
        end
      end
      OpAnd:   w_scDout = inA & inB;
      OpOr:    w_scDout = inA | inB;
      OpXor:   w_scDout = inA ^ inB;
      OpXnor:  w_scDout = ~(inA ^ inB);
      OpNand:  w_scDout = ~(inA & inB);
      OpNor:   w_scDout = ~(inA | inB);
      default: w_scDout = '0;
    endcase
    // Invalid opcodes C-F deliberately leave the zero flag clear.
    if (sel_tmp <= OpNor) begin
      w_scFlags[0] = (w_scDout == '0);
    end
  end

  // Control FSM plus result registers. Outputs only change when entering
  // DONE, so they stay stable for the whole output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_prod     <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_dout     <= '0;
      r_doutHi   <= '0;
      r_flags    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op       <= sel_tmp;
            r_cnt      <= CNT_W'(1);
            r_mcand    <= w_mcandNext;
            r_mplier   <= w_mplierNext;
            r_prod     <= w_prodNext;
            r_divisor  <= w_divisor;
            r_dividend <= w_dividendNext;
            r_rem      <= w_remNext;
            r_quot     <= w_quotNext;
            if (sel_tmp == OpMul) begin
              if (EarlyTerm && (w_mplierNext == '0)) begin
                r_dout   <= w_prodNext[WIDTH-1:0];
                r_doutHi <= w_prodNext[2*WIDTH-1:WIDTH];
                r_flags  <= w_mulFlags;
                r_state  <= DONE;
              end else begin
                r_state <= BUSY;
              end
            end else if ((sel_tmp == OpDiv) && (inB != '0)) begin
              r_state <= BUSY;
            end else begin
              r_dout   <= w_scDout;
              r_doutHi <= w_scHi;
              r_flags  <= w_scFlags;
              r_state  <= DONE;
            end
          end
        end
        BUSY: begin
          r_cnt      <= r_cnt + CNT_W'(1);
          r_mcand    <= w_mcandNext;
          r_mplier   <= w_mplierNext;
          r_prod     <= w_prodNext;
          r_dividend <= w_dividendNext;
          r_rem      <= w_remNext;
          r_quot     <= w_quotNext;
          if (r_op == OpMul) begin
            if ((r_cnt == LastIter) || (EarlyTerm && (w_mplierNext == '0))) begin
              r_dout   <= w_prodNext[WIDTH-1:0];
              r_doutHi <= w_prodNext[2*WIDTH-1:WIDTH];
              r_flags  <= w_mulFlags;
              r_state  <= DONE;
            end
          end else if (r_cnt == LastIter) begin
            r_dout   <= w_quotNext;
            r_doutHi <= w_remNext;
            r_flags  <= w_divFlags;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : scoreboard testbench for alu_seq (WIDTH = 8).
// Stimulus pushes hand-computed expected results into a queue; a monitor
// compares every presented result against the head of the queue and pops
// it on the output handshake.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 8;

`ifdef ALU_SEQ_MUL_EARLY_TERM_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  inA;
  logic [W-1:0]  inB;
  logic [3:0]    sel_tmp;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout;
  logic [W-1:0]  dout_hi;
  logic [3:0]    flags;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] h;
    logic [3:0]   f;
    int           lat;
    int           acc;
  } exp_t;

  exp_t scb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   seen     = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inA      (inA),
    .inB      (inB),
    .sel_tmp  (sel_tmp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .dout_hi  (dout_hi),
    .flags    (flags)
  );

  // Free-running clock and a cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Issues one operation once the DUT is ready; when push is set the expected
  // response is queued for the monitor. Returns just after the accept edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] ed,
                               input logic [W-1:0] eh, input logic [3:0] ef,
                               input int lat, input bit push);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      inA      = a;
      inB      = b;
      sel_tmp  = op;
      @(posedge clk); #1;
      in_valid = 1'b0;
      inA      = ~a;
      inB      = ~b;
      checkOutput("in_ready_after_accept", 32'(in_ready), 32'd0);
      if (push) begin
        e.d = ed; e.h = eh; e.f = ef; e.lat = lat; e.acc = cyc;
        scb.push_back(e);
      end
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (scb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_timeout", 32'(scb.size()), 32'd0);
  endtask

  // Monitor: compares every cycle a result is presented, pops on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (scb.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = scb[0];
        if (!seen) begin
          seen = 1'b1;
          checkOutput("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
        checkOutput("dout", 32'(dout), 32'(e.d));
        checkOutput("dout_hi", 32'(dout_hi), 32'(e.h));
        checkOutput("flags", 32'(flags), 32'(e.f));
        checkOutput("in_ready_while_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(scb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    inA       = '0;
    inB       = '0;
    sel_tmp   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_dout_hi", 32'(dout_hi), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // op, A, B, dout, dout_hi, flags, latency
    applyStimulus(4'h0, 8'd200, 8'd100, 8'd44, 8'h00, 4'b0100, 1, 1'b1);
    applyStimulus(4'h2, 8'd20, 8'd15, 8'h2C, 8'h01, 4'b0100, Early ? 4 : 8, 1'b1);
    applyStimulus(4'h3, 8'd100, 8'd7, 8'd14, 8'd2, 4'b0000, 8, 1'b1);
    applyStimulus(4'h3, 8'd5, 8'd0, 8'd0, 8'd0, 4'b0101, 1, 1'b1);
    applyStimulus(4'h3, 8'd3, 8'd10, 8'd0, 8'd3, 4'b1001, 8, 1'b1);
    applyStimulus(4'h4, 8'h81, 8'd1, 8'h02, 8'h00, 4'b0010, 1, 1'b1);
    applyStimulus(4'h4, 8'h01, 8'd7, 8'h80, 8'h00, 4'b0000, 1, 1'b1);
    applyStimulus(4'h4, 8'h01, 8'd8, 8'h00, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus(4'h4, 8'h81, 8'd0, 8'h81, 8'h00, 4'b0000, 1, 1'b1);
    applyStimulus(4'h5, 8'h81, 8'd9, 8'h00, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus(4'h5, 8'h81, 8'd1, 8'h40, 8'h00, 4'b0010, 1, 1'b1);
    applyStimulus(4'h1, 8'd3, 8'd5, 8'hFE, 8'h00, 4'b1000, 1, 1'b1);
    applyStimulus(4'h6, 8'hF0, 8'h0F, 8'h00, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus(4'h7, 8'h12, 8'h34, 8'h36, 8'h00, 4'b0000, 1, 1'b1);
    applyStimulus(4'h8, 8'h0F, 8'h0F, 8'h00, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus(4'h9, 8'hAA, 8'h55, 8'h00, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus(4'hA, 8'hFF, 8'h0F, 8'hF0, 8'h00, 4'b0000, 1, 1'b1);
    applyStimulus(4'hB, 8'h00, 8'h00, 8'hFF, 8'h00, 4'b0000, 1, 1'b1);
    applyStimulus(4'hC, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1, 1'b1);
    applyStimulus(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus(4'h2, 8'd7, 8'd0, 8'h00, 8'h00, 4'b0001, Early ? 1 : 8, 1'b1);
    applyStimulus(4'h2, 8'd0, 8'd5, 8'h00, 8'h00, 4'b0001, Early ? 3 : 8, 1'b1);
    applyStimulus(4'h2, 8'd255, 8'd255, 8'h01, 8'hFE, 4'b0100, 8, 1'b1);
    waitDrain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    applyStimulus(4'h2, 8'd3, 8'd3, 8'd9, 8'h00, 4'b0000, Early ? 2 : 8, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_out_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_out_valid_cleared", 32'(out_valid), 32'd0);
    checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
    waitDrain();

    // Reset mid-MUL: the pending product must never appear.
    applyStimulus(4'h2, 8'd255, 8'd255, 8'h01, 8'hFE, 4'b0100, 8, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_dout", 32'(dout), 32'd0);
    checkOutput("abort_dout_hi", 32'(dout_hi), 32'd0);
    checkOutput("abort_flags", 32'(flags), 32'd0);
    applyStimulus(4'h0, 8'd1, 8'd1, 8'd2, 8'h00, 4'b0000, 1, 1'b1);
    waitDrain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
